// File: rtl/logic_mux2_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_mux2_sel_pkg
//  Description : Shared types and bit-position constants for logic_mux2_sel.
//                func_e encodes the reduction applied to the selected
//                operand. SEL_BIT/FN_MSB/FN_LSB locate the fields inside the
//                control vector c, which is declared [0:WIDTH-1].
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_mux2_sel_pkg;

   typedef enum logic [1:0] {
      FN_AND = 2'b00,
      FN_OR  = 2'b01,
      FN_XOR = 2'b10,
      FN_MAJ = 2'b11
   } func_e;

   localparam int SEL_BIT = 0;
   localparam int FN_MSB  = 1;
   localparam int FN_LSB  = 2;

endpackage : logic_mux2_sel_pkg
`default_nettype wire

// File: rtl/logic_mux2_sel_if.sv
`default_nettype none
// ============================================================================
//  Module      : logic_mux2_sel_if
//  Description : Bus bundle for logic_mux2_sel.
//                en     - update enable
//                a, b   - operands, index 0 is the MSB
//                c      - control (c[0] select, c[1:2] function code)
//                y      - registered 1-bit result
//                ones_cnt - saturating count of updates to 1
//                           (only when LOGIC_MUX2_SEL_CNT_EN is defined)
//                master drives en/a/b/c, slave drives y (and ones_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
interface logic_mux2_sel_if #(
   parameter int WIDTH = 3
);
   logic               en;
   logic [0:WIDTH-1]   a;
   logic [0:WIDTH-1]   b;
   logic [0:WIDTH-1]   c;
   logic               y;
`ifdef LOGIC_MUX2_SEL_CNT_EN
   logic [7:0]         ones_cnt;
`endif

`ifdef LOGIC_MUX2_SEL_CNT_EN
   modport master (output en, a, b, c, input y, ones_cnt);
   modport slave  (input en, a, b, c, output y, ones_cnt);
`else
   modport master (output en, a, b, c, input y);
   modport slave  (input en, a, b, c, output y);
`endif

endinterface : logic_mux2_sel_if
`default_nettype wire

// File: rtl/logic_mux2_sel_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : logic_mux2_sel_reduce
//  Description : Purely combinational 1-bit reduction of a WIDTH-bit vector.
//                fn selects AND / OR / XOR (odd parity) / majority, where
//                majority is 1 when popcount(v) >= ceil(WIDTH/2).
//  Ports       : v   [0:WIDTH-1] input vector
//                fn  func_e      reduction select
//                res             1-bit result
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_mux2_sel_reduce
   import logic_mux2_sel_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  wire logic [0:WIDTH-1] v,
   input  wire func_e            fn,
   output logic                  res
);

   localparam int                CW     = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]     MAJ_TH = CW'((WIDTH + 1) / 2);

   logic [CW-1:0] ones;

   always_comb begin
      ones = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + CW'(v[i]);
      end
   end

   always_comb begin
      res = 1'b0;
      case (fn)
         FN_AND:  res = &v;
         FN_OR:   res = |v;
         FN_XOR:  res = ^v;
         FN_MAJ:  res = (ones >= MAJ_TH);
         default: res = 1'b0;
      endcase
   end

endmodule : logic_mux2_sel_reduce
`default_nettype wire

// File: rtl/logic_mux2_sel.sv
`default_nettype none
// ============================================================================
//  Module      : logic_mux2_sel
//  Description : Registered 2:1 vector mux followed by a selectable 1-bit
//                reduction. c[0] picks a (0) or b (1); c[1:2] picks the
//                reduction; the result is registered onto y when en is high.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset (y <= RESET_VAL)
//                bus    logic_mux2_sel_if.slave (en, a, b, c in; y out)
//  Options     : LOGIC_MUX2_SEL_CNT_EN adds bus.ones_cnt, a saturating
//                8-bit count of edges at which y is updated to 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_mux2_sel
   import logic_mux2_sel_pkg::*;
#(
   parameter int   WIDTH     = 3,
   parameter logic RESET_VAL = 1'b0
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   logic_mux2_sel_if.slave    bus
);

   logic [0:WIDTH-1] v;
   func_e            fn;
   logic             red_res;
   logic             y_d;
   logic             y_q;

   // Operand select and function decode straight from the control fields.
   always_comb begin
      v  = bus.c[SEL_BIT] ? bus.b : bus.a;
      fn = func_e'({bus.c[FN_MSB], bus.c[FN_LSB]});
   end

   // Control bits beyond the function code carry no meaning.
   generate
      if (WIDTH > 3) begin : g_unused_c
         logic unused_c_hi;
         assign unused_c_hi = ^bus.c[3:WIDTH-1];
      end
   endgenerate

   logic_mux2_sel_reduce #(
      .WIDTH (WIDTH)
   ) u_reduce (
      .v   (v),
      .fn  (fn),
      .res (red_res)
   );

   always_comb begin
      y_d = y_q;
      if (bus.en) begin
         y_d = red_res;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= RESET_VAL;
      end else begin
         y_q <= y_d;
      end
   end

   assign bus.y = y_q;

`ifdef LOGIC_MUX2_SEL_CNT_EN
   logic [7:0] ones_cnt_d;
   logic [7:0] ones_cnt_q;

   // Counts only edges that actually load a 1; sticks at all-ones.
   always_comb begin
      ones_cnt_d = ones_cnt_q;
      if (bus.en && red_res && (ones_cnt_q != 8'hFF)) begin
         ones_cnt_d = ones_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_cnt_q <= 8'h00;
      end else begin
         ones_cnt_q <= ones_cnt_d;
      end
   end

   assign bus.ones_cnt = ones_cnt_q;
`endif

endmodule : logic_mux2_sel
`default_nettype wire

// File: tb/tb_logic_mux2_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_mux2_sel
//  Description : Self-checking bench for logic_mux2_sel (WIDTH = 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_mux2_sel;

   logic clk;
   logic rst_n;

   logic_mux2_sel_if #(.WIDTH(3)) bus ();

   logic_mux2_sel #(
      .WIDTH     (3),
      .RESET_VAL (1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [2:0] a;
      logic [2:0] b;
      logic [2:0] c;
      logic       exp_y;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic en, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      bus.en = en;
      bus.a  = a;
      bus.b  = b;
      bus.c  = c;
   endtask

   initial begin
      // en    a     b     c     y
      vecs[0]  = '{1'b1, 3'd1, 3'd0, 3'd2, 1'b1}; // a, XOR(001)
      vecs[1]  = '{1'b1, 3'd2, 3'd1, 3'd3, 1'b0}; // a, MAJ(010)
      vecs[2]  = '{1'b1, 3'd7, 3'd6, 3'd7, 1'b1}; // b, MAJ(110)
      vecs[3]  = '{1'b1, 3'd3, 3'd2, 3'd4, 1'b0}; // b, AND(010)
      vecs[4]  = '{1'b1, 3'd4, 3'd3, 3'd5, 1'b1}; // b, OR(011)
      vecs[5]  = '{1'b0, 3'd0, 3'd0, 3'd1, 1'b1}; // hold
      vecs[6]  = '{1'b0, 3'd0, 3'd0, 3'd1, 1'b1}; // hold
      vecs[7]  = '{1'b0, 3'd0, 3'd0, 3'd1, 1'b1}; // hold
      vecs[8]  = '{1'b1, 3'd0, 3'd0, 3'd1, 1'b0}; // a, OR(000)
      vecs[9]  = '{1'b1, 3'd7, 3'd0, 3'd0, 1'b1}; // a, AND(111)
      vecs[10] = '{1'b1, 3'd6, 3'd7, 3'd0, 1'b0}; // a, AND(110)
      vecs[11] = '{1'b1, 3'd5, 3'd0, 3'd2, 1'b0}; // a, XOR(101)
      vecs[12] = '{1'b1, 3'd7, 3'd4, 3'd7, 1'b0}; // b, MAJ(100)
      vecs[13] = '{1'b1, 3'd0, 3'd5, 3'd7, 1'b1}; // b, MAJ(101)
      vecs[14] = '{1'b1, 3'd0, 3'd7, 3'd6, 1'b1}; // b, XOR(111)
      vecs[15] = '{1'b1, 3'd1, 3'd0, 3'd1, 1'b1}; // a, OR(001)

      // Reset with no clock edge yet.
      rst_n = 1'b0;
      drive(1'b0, 3'd0, 3'd0, 3'd0);
      #3;
      chk("reset_no_clk_y", {7'd0, bus.y}, 8'd0);
`ifdef LOGIC_MUX2_SEL_CNT_EN
      chk("reset_cnt", bus.ones_cnt, 8'd0);
`endif

      // Edges while held in reset must not update y.
      drive(1'b1, 3'd1, 3'd0, 3'd2);
      @(posedge clk); #1;
      chk("reset_held_y", {7'd0, bus.y}, 8'd0);

      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].en, vecs[i].a, vecs[i].b, vecs[i].c);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_y", i), {7'd0, bus.y}, {7'd0, vecs[i].exp_y});
      end

`ifdef LOGIC_MUX2_SEL_CNT_EN
      // Vectors 0,2,4,9,13,14,15 loaded a 1 with en high.
      chk("cnt_after_vecs", bus.ones_cnt, 8'd7);
`endif

      // Asynchronous reset between edges while y=1.
      @(negedge clk);
      drive(1'b1, 3'd7, 3'd0, 3'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_y", {7'd0, bus.y}, 8'd0);
`ifdef LOGIC_MUX2_SEL_CNT_EN
      chk("async_rst_cnt", bus.ones_cnt, 8'd0);
`endif
      @(posedge clk); #1;
      chk("async_rst_edge_y", {7'd0, bus.y}, 8'd0);

      // Release; first enabled edge loads OR(111) = 1.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("release_first_y", {7'd0, bus.y}, 8'd1);
`ifdef LOGIC_MUX2_SEL_CNT_EN
      chk("cnt_one", bus.ones_cnt, 8'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("cnt_five", bus.ones_cnt, 8'd5);
      // en low must not count.
      @(negedge clk);
      bus.en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("cnt_hold_en0", bus.ones_cnt, 8'd5);
      @(negedge clk);
      bus.en = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      chk("cnt_saturate", bus.ones_cnt, 8'hFF);
      repeat (3) @(posedge clk);
      #1;
      chk("cnt_stick", bus.ones_cnt, 8'hFF);
`else
      repeat (5) @(posedge clk);
      #1;
      chk("steady_y", {7'd0, bus.y}, 8'd1);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_logic_mux2_sel
`default_nettype wire
